// File: rtl/blowfish128_ffunc.sv
// -----------------------------------------------------------------------------
// blowfish128_ffunc
//
// Blowfish-128 round function F. The block captures a 64-bit half-block from
// the core, performs eight sequential S-box reads through a synchronous,
// single-port S-box read interface and folds the returned words into a 64-bit
// result using alternating add/xor, all modulo 2^64.
//
// Lookup k (k = 0..7) reads box k at the index given by byte k of the captured
// input, where byte 0 is the most significant byte. The fold sequence is:
//   acc = S0 ; acc += S1 ; acc ^= S2 ; acc += S3 ;
//   acc ^= S4 ; acc += S5 ; acc ^= S6 ; acc += S7
//
// Ports
//   Clk           in   1   clock, rising edge
//   RstN          in   1   asynchronous, active-low reset
//   ffunc_enable  in   1   request from core, held high with stable X
//   X             in  64   F-function input half-block
//   ffunc_ready   out  1   one-cycle pulse, Y holds a new result
//   Y             out 64   F result, registered, held until next completion
//   sbox_valid    in   1   S-box store has been initialised
//   sbox_en       out  1   S-box read strobe
//   sbox_addr     out 11   {box[2:0], index[7:0]}
//   sbox_rdata    in  64   read data, valid the cycle after sbox_en
// -----------------------------------------------------------------------------
module blowfish128_ffunc (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        ffunc_enable,
  input  logic [63:0] X,
  output logic        ffunc_ready,
  output logic [63:0] Y,
  input  logic        sbox_valid,
  output logic        sbox_en,
  output logic [10:0] sbox_addr,
  input  logic [63:0] sbox_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_WAITLOW = 2'd3;

  // Byte k of a half-block; byte 0 is the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [63:0] xr, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = xr[63:56];
      3'd1:    b = xr[55:48];
      3'd2:    b = xr[47:40];
      3'd3:    b = xr[39:32];
      3'd4:    b = xr[31:24];
      3'd5:    b = xr[23:16];
      3'd6:    b = xr[15:8];
      3'd7:    b = xr[7:0];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  // One fold step: word 0 seeds the accumulator, odd words add, even words xor.
  function automatic logic [63:0] fold_step(input logic [63:0] acc,
                                            input logic [63:0] data,
                                            input logic [2:0]  k);
    logic [63:0] r;
    if (k == 3'd0) begin
      r = data;
    end else if (k[0]) begin
      r = acc + data;
    end else begin
      r = acc ^ data;
    end
    return r;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [63:0] xr_r, xr_s;
  logic [3:0]  idx_r, idx_s;
  logic [63:0] acc_r, acc_s;
  logic [63:0] y_r, y_s;
  logic        ready_r, ready_s;
  logic        sbox_en_r, sbox_en_s;
  logic [10:0] sbox_addr_r, sbox_addr_s;

  // idx_r counts RUN edges since capture; edge n issues read n and folds word n-2.
  logic [3:0]  next_idx_s;
  logic [2:0]  fold_k_s;

  assign next_idx_s = idx_r + 4'd1;
  // Modulo-8 subtraction is exact for the fold window n = 2..9.
  assign fold_k_s   = next_idx_s[2:0] - 3'd2;

  // Next-state, read-issue and fold logic.
  always_comb begin
    state_s     = state_r;
    xr_s        = xr_r;
    idx_s       = idx_r;
    acc_s       = acc_r;
    y_s         = y_r;
    ready_s     = 1'b0;
    sbox_en_s   = 1'b0;
    sbox_addr_s = 11'd0;

    case (state_r)
      ST_IDLE: begin
        if (ffunc_enable && sbox_valid) begin
          // Read 0 is issued straight from X on the capture edge.
          xr_s        = X;
          idx_s       = 4'd0;
          acc_s       = 64'd0;
          sbox_en_s   = 1'b1;
          sbox_addr_s = {3'd0, byte_sel(X, 3'd0)};
          state_s     = ST_RUN;
        end else begin
          state_s     = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!ffunc_enable) begin
          // Abort: partial result is discarded, Y and ready untouched.
          idx_s   = 4'd0;
          acc_s   = 64'd0;
          state_s = ST_IDLE;
        end else begin
          idx_s = next_idx_s;

          if (next_idx_s <= 4'd7) begin
            sbox_en_s   = 1'b1;
            sbox_addr_s = {next_idx_s[2:0], byte_sel(xr_r, next_idx_s[2:0])};
          end else begin
            sbox_en_s   = 1'b0;
            sbox_addr_s = 11'd0;
          end

          if (next_idx_s >= 4'd2) begin
            acc_s = fold_step(acc_r, sbox_rdata, fold_k_s);
          end else begin
            acc_s = acc_r;
          end

          if (next_idx_s == 4'd9) begin
            y_s     = acc_s;
            ready_s = 1'b1;
            idx_s   = 4'd0;
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end

      ST_DONE: begin
        acc_s   = 64'd0;
        state_s = ST_WAITLOW;
      end

      ST_WAITLOW: begin
        // One result per request: wait for the core to release enable.
        if (!ffunc_enable) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAITLOW;
        end
      end

      default: begin
        idx_s   = 4'd0;
        acc_s   = 64'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r     <= ST_IDLE;
      xr_r        <= 64'd0;
      idx_r       <= 4'd0;
      acc_r       <= 64'd0;
      y_r         <= 64'd0;
      ready_r     <= 1'b0;
      sbox_en_r   <= 1'b0;
      sbox_addr_r <= 11'd0;
    end else begin
      state_r     <= state_s;
      xr_r        <= xr_s;
      idx_r       <= idx_s;
      acc_r       <= acc_s;
      y_r         <= y_s;
      ready_r     <= ready_s;
      sbox_en_r   <= sbox_en_s;
      sbox_addr_r <= sbox_addr_s;
    end
  end

  assign ffunc_ready = ready_r;
  assign Y           = y_r;
  assign sbox_en     = sbox_en_r;
  assign sbox_addr   = sbox_addr_r;

endmodule

// File: tb/tb_blowfish128_ffunc.sv
// -----------------------------------------------------------------------------
// tb_blowfish128_ffunc
//
// Scoreboard bench for blowfish128_ffunc. A behavioural S-box store answers
// reads one cycle after sbox_en. Stimulus pushes the expected Y and the eight
// expected read addresses of each request; a monitor process pops and compares
// whenever the DUT strobes sbox_en or pulses ffunc_ready. Timing checks from
// the stimulus side are queued to the same monitor, which owns the counters.
// -----------------------------------------------------------------------------
module tb_blowfish128_ffunc;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        ffunc_enable = 1'b0;
  logic [63:0] X = 64'd0;
  logic        ffunc_ready;
  logic [63:0] Y;
  logic        sbox_valid = 1'b0;
  logic        sbox_en;
  logic [10:0] sbox_addr;
  logic [63:0] sbox_rdata = 64'd0;

  blowfish128_ffunc dut (
    .Clk          (Clk),
    .RstN         (RstN),
    .ffunc_enable (ffunc_enable),
    .X            (X),
    .ffunc_ready  (ffunc_ready),
    .Y            (Y),
    .sbox_valid   (sbox_valid),
    .sbox_en      (sbox_en),
    .sbox_addr    (sbox_addr),
    .sbox_rdata   (sbox_rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic [63:0] sbox_mem [0:2047];
  chk_t        chk_q [$];
  logic [63:0] exp_q [$];
  logic [10:0] addr_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int rdy_cnt     = 0;
  int en_cnt      = 0;
  int cyc_cnt     = 0;
  int prev_e0     = -1;

  // Synchronous S-box store and cycle counter.
  always @(posedge Clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (sbox_en) sbox_rdata <= sbox_mem[sbox_addr];
  end

  // Reference F: eight lookups, odd words add, even words (k>=2) xor.
  function automatic logic [63:0] f_ref(input logic [63:0] x);
    logic [63:0] acc;
    logic [63:0] v;
    acc = sbox_mem[{3'd0, x[63:56]}];
    for (int k = 1; k < 8; k++) begin
      v = sbox_mem[k * 256 + int'(x[63 - 8 * k -: 8])];
      if (k % 2 == 1) acc = acc + v;
      else            acc = acc ^ v;
    end
    return acc;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 2048; i++) begin
      case (mode)
        0:       sbox_mem[i] = 64'd0;
        1:       sbox_mem[i] = 64'(i % 256);
        2:       sbox_mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        default: sbox_mem[i] = {$urandom, $urandom};
      endcase
    end
  endtask

  task automatic push_addrs(input logic [63:0] x);
    for (int k = 0; k < 8; k++) addr_q.push_back(11'(k * 256 + int'(x[63 - 8 * k -: 8])));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // Issue one core-style request and follow it to completion.
  task automatic run_req(input logic [63:0] x, input logic [63:0] y_exp,
                         input int hold, input bit chk_period);
    int e0;
    int r0;
    int n0;
    bit seen;
    X            = x;
    ffunc_enable = 1'b1;
    e0 = cyc_cnt + 1;
    r0 = rdy_cnt;
    n0 = en_cnt;
    exp_q.push_back(y_exp);
    push_addrs(x);
    if (chk_period && prev_e0 >= 0) check("period", 64'(e0 - prev_e0), 64'd12);
    prev_e0 = e0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (ffunc_ready) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 64'd0, 64'd1);
    else       check("latency", 64'(cyc_cnt - e0), 64'd9);
    check("reads_per_req", 64'(en_cnt - n0), 64'd8);
    if (hold > 0) begin
      repeat (hold) step();
      check("ready_once", 64'(rdy_cnt - r0), 64'd1);
      check("no_more_reads", 64'(en_cnt - n0), 64'd8);
    end
    step();
    ffunc_enable = 1'b0;
    step();
  endtask

  // Monitor: drains queued checks, scores reads and results.
  logic [63:0] y_prev   = 64'd0;
  logic        rdy_prev = 1'b0;
  chk_t        mc;
  logic [63:0] me;
  logic [10:0] ma;

  initial begin
    forever begin
      @(negedge Clk);
      while (chk_q.size() > 0) begin
        mc = chk_q.pop_front();
        vectors++;
        if (mc.act !== mc.exp) begin
          miscompares++;
          $display("FAIL %s: got %0h expected %0h", mc.name, mc.act, mc.exp);
        end
      end
      if (RstN) begin
        if (ffunc_ready) begin
          rdy_cnt++;
          vectors++;
          if (rdy_prev !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_pulse: ready high two cycles in a row");
          end
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ready: Y=%h with no request pending", Y);
          end else begin
            me = exp_q.pop_front();
            if (Y !== me) begin
              miscompares++;
              $display("FAIL y_result: got %h expected %h", Y, me);
            end
          end
        end else begin
          vectors++;
          if (Y !== y_prev) begin
            miscompares++;
            $display("FAIL y_hold: Y changed to %h from %h without ready", Y, y_prev);
          end
        end
        if (sbox_en) begin
          en_cnt++;
          vectors++;
          if (addr_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_read: addr %h with no read pending", sbox_addr);
          end else begin
            ma = addr_q.pop_front();
            if (sbox_addr !== ma) begin
              miscompares++;
              $display("FAIL sbox_addr: got %h expected %h", sbox_addr, ma);
            end
          end
        end
      end
      rdy_prev = ffunc_ready;
      y_prev   = Y;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus.
  logic [63:0] xv;
  int          r0;
  int          n0;

  initial begin
    fill(0);
    step();
    check("rst_ready", 64'(ffunc_ready), 64'd0);
    check("rst_y", Y, 64'd0);
    check("rst_en", 64'(sbox_en), 64'd0);
    check("rst_addr", 64'(sbox_addr), 64'd0);
    #1 RstN = 1'b1;
    sbox_valid = 1'b1;
    step();

    // All-zero S-boxes, enable held: one pulse, eight reads.
    run_req(64'h0123_4567_89AB_CDEF, 64'd0, 6, 1'b0);

    // All-ones S-boxes: carry wrap and xor.
    fill(2);
    xv = {$urandom, $urandom};
    run_req(xv, 64'd0, 0, 1'b0);

    // Identity S-boxes.
    fill(1);
    run_req(64'h0102_0304_0506_0708, 64'h8, 0, 1'b0);

    // Abort four cycles after capture.
    X            = 64'h0102_0304_0506_0708;
    ffunc_enable = 1'b1;
    exp_q.push_back(64'h8);
    push_addrs(X);
    r0 = rdy_cnt;
    repeat (4) step();
    ffunc_enable = 1'b0;
    step();
    check("abort_en_low", 64'(sbox_en), 64'd0);
    addr_q.delete();
    exp_q.delete();
    repeat (12) step();
    check("abort_no_ready", 64'(rdy_cnt - r0), 64'd0);
    check("abort_y_kept", Y, 64'h8);
    run_req(64'h0102_0304_0506_0708, 64'h8, 0, 1'b0);

    // sbox_valid low blocks capture.
    xv           = {$urandom, $urandom};
    sbox_valid   = 1'b0;
    X            = xv;
    ffunc_enable = 1'b1;
    r0 = rdy_cnt;
    n0 = en_cnt;
    repeat (5) step();
    check("novalid_reads", 64'(en_cnt - n0), 64'd0);
    check("novalid_ready", 64'(rdy_cnt - r0), 64'd0);
    sbox_valid = 1'b1;
    run_req(xv, f_ref(xv), 0, 1'b0);

    // Enable lingering 20 cycles after ready.
    xv = {$urandom, $urandom};
    run_req(xv, f_ref(xv), 20, 1'b0);

    // Back-to-back handshakes on random S-boxes, reset during the 4th.
    fill(3);
    prev_e0 = -1;
    for (int n = 0; n < 8; n++) begin
      xv = {$urandom, $urandom};
      if (n == 3) begin
        X            = xv;
        ffunc_enable = 1'b1;
        exp_q.push_back(f_ref(xv));
        push_addrs(xv);
        repeat (4) step();
        #1 RstN = 1'b0;
        #1;
        check("midrst_ready", 64'(ffunc_ready), 64'd0);
        check("midrst_y", Y, 64'd0);
        check("midrst_en", 64'(sbox_en), 64'd0);
        check("midrst_addr", 64'(sbox_addr), 64'd0);
        exp_q.delete();
        addr_q.delete();
        ffunc_enable = 1'b0;
        prev_e0 = -1;
        step();
        #1 RstN = 1'b1;
        step();
      end else begin
        run_req(xv, f_ref(xv), 0, (n != 0 && n != 4));
      end
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blowfish128_ffunc.md
# blowfish128_ffunc

Blowfish-128 round function F. It serves the core's `ffunc_enable`/`X` → `ffunc_ready`/`Y` handshake: it captures a 64-bit half-block, performs eight sequential S-box lookups through a synchronous single-port S-box read interface, and folds the results with alternating add/xor into a 64-bit result. The S-box store is populated by the subkey generator; this block only reads it.

## Interface
- No parameters. Widths are fixed: 64-bit data, 8 S-boxes, 256 entries of 64 bits each.
- Clk  in  1  clock, rising edge
- RstN  in  1  asynchronous, active-low reset
- ffunc_enable  in  1  request from core; held high with stable X until ready seen
- X  in  64  F-function input half-block
- ffunc_ready  out  1  one-cycle pulse: Y holds new result
- Y  out  64  F result, registered, held until next completion
- sbox_valid  in  1  S-box store initialised (from subkey generator)
- sbox_en  out  1  S-box read strobe
- sbox_addr  out  11  {box[2:0], index[7:0]}
- sbox_rdata  in  64  read data, valid the cycle after sbox_en/sbox_addr

## Operation
- Byte k of the captured input xr: k=0 is xr[63:56], k=7 is xr[7:0]. Lookup k reads box k at index byte k.
- Fold (all arithmetic mod 2^64):
  - acc = S0[b0]
  - acc += S1[b1]
  - acc ^= S2[b2]
  - acc += S3[b3]
  - acc ^= S4[b4]
  - acc += S5[b5]
  - acc ^= S6[b6]
  - acc += S7[b7]
  - Rule: odd k adds, even k≥2 xors.
- FSM states:
  - IDLE:
    - ffunc_enable & sbox_valid → capture xr=X, idx=0, go RUN.
    - ffunc_enable & ~sbox_valid → stay in IDLE, no reads.
  - RUN:
    - Drive sbox_en=1 and sbox_addr={idx, byte idx} while idx ≤ 7, then increment idx.
    - Fold sbox_rdata into acc one cycle after each read.
    - After the 8th fold: Y←acc, go DONE.
  - DONE:
    - ffunc_ready=1 for exactly this cycle, then go WAITLOW.
  - WAITLOW:
    - Stay until ffunc_enable=0, then go IDLE.
    - Guarantees one result per request even if enable lingers.
- Abort: ffunc_enable low in RUN → go IDLE next edge. Y and ready are unaffected, and the partial acc is discarded.
- sbox_valid falling in RUN is ignored; the computation completes.
- X changes after capture are ignored.

## Timing
- Reset values: ffunc_ready=0, Y=0, sbox_en=0, sbox_addr=0, state IDLE, acc=0, idx=0. Reset mid-computation returns to these immediately (asynchronous); no ready pulse is emitted.
- Let E0 be the edge sampling enable&sbox_valid in IDLE.
- Reads: addresses for k=0..7 are driven in the cycles after edges E0..E0+7, one per cycle. sbox_en is high for exactly 8 consecutive cycles.
- Folds: data k is folded at edge E0+k+2. The final fold and Y update happen at edge E0+9.
- Latency: ffunc_ready is high in the cycle following E0+9, i.e. asserted 9 cycles after capture, for 1 cycle.
- Core protocol: the core drops enable one cycle after ready and re-raises it with new X one cycle later. Next E0 is 2 cycles after the ready cycle, so the round period is 12 cycles.
- Y changes only at completion edges.

## Test plan
- All S-box entries 0; X=64'h0123456789ABCDEF; enable held → Y=0. Ready is a single pulse 9 cycles after capture, and sbox_en is high for 8 cycles.
- Model S_k[i]=i zero-extended; X=64'h0102030405060708.
  - Addresses are 11'h001, 11'h102, 11'h203 … 11'h708.
  - Y=64'h8.
- All S-box entries 64'hFFFFFFFFFFFFFFFF; any X → Y=64'h0. Exercises add carry wrap and xor.
- Abort: S_k[i]=i, previous Y=64'h8. Drop enable 4 cycles after capture → no ready pulse, Y stays 64'h8, sbox_en low next cycle. Re-request with X=64'h0102030405060708 → Y=64'h8 at nominal latency.
- sbox_valid=0 with enable high for 5 cycles → sbox_en stays 0 and no ready. Raise sbox_valid → capture on that edge, ready 9 cycles later.
- Enable kept high 20 cycles after ready → exactly one ready pulse and no further sbox_en. Run 8 back-to-back core-style handshakes with RstN pulsed low during the 4th → outputs return to reset values immediately; remaining requests complete correctly with a 12-cycle period.
